mem_bus_arbiter: RTL and testbench

- Shares the single Avalon memory-mapped master port of the CPU between two requesters: instruction fetch (read-only) and data load/store (read/write with byteenable).
- Sits between the CPU control path (FETCH / EXEC / MEM_ACCESS sequencing) and the external memory bus.
- Grants one requester at a time, holds the grant across waitrequest stalls, and alternates between requesters when both are pending.

---
 rtl/mips_cpu_definitions.sv | 17 +
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_definitions.sv
// Shared CPU definitions used by the memory bus arbiter.
//   arb_state_t : arbiter ownership state; its encoding doubles as the
//                 grant value presented on the arbiter's grant output.
//   GRANT_*     : grant encodings (00 none, 01 fetch, 10 data).
package mips_cpu_definitions;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = GRANT_NONE,
    ARB_OWN_I = GRANT_I,
    ARB_OWN_D = GRANT_D
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the CPU's single Avalon-MM master port.
// Instruction fetch (read-only) and data load/store share the bus; one owner
// at a time, grant held across waitrequest stalls, alternation on contention.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   i_address/i_read    : fetch request; i_waitrequest/i_readdata back
//   d_address/d_read/d_write/d_writedata/d_byteenable : data request;
//                         d_waitrequest/d_readdata back
//   address/read/write/writedata/byteenable : bus master outputs
//   waitrequest/readdata: bus slave responses
//   grant               : current owner (00 none, 01 fetch, 10 data)
module mem_bus_arbiter
  import mips_cpu_definitions::*;
#(
  parameter bit          DATA_FIRST = 1'b1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_writedata,
  input  logic [3:0]        d_byteenable,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  output logic [1:0]        grant
);

  arb_state_t state;
  logic       i_req;
  logic       d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Ownership transition. A completing owner hands the bus straight to the
  // other requester if it is waiting, which gives strict alternation under
  // continuous contention. Only a live request is ever granted.
  function automatic arb_state_t next_owner(input arb_state_t cur,
                                            input logic       ireq,
                                            input logic       dreq,
                                            input logic       stall);
    arb_state_t nxt;
    nxt = cur;
    case (cur)
      ARB_IDLE: begin
        if (ireq && dreq) nxt = DATA_FIRST ? ARB_OWN_D : ARB_OWN_I;
        else if (dreq)    nxt = ARB_OWN_D;
        else if (ireq)    nxt = ARB_OWN_I;
      end
      ARB_OWN_I: begin
        // Dropping the request mid-transfer abandons ownership.
        if (!ireq)       nxt = ARB_IDLE;
        else if (!stall) nxt = dreq ? ARB_OWN_D : ARB_IDLE;
      end
      ARB_OWN_D: begin
        if (!dreq)       nxt = ARB_IDLE;
        else if (!stall) nxt = ireq ? ARB_OWN_I : ARB_IDLE;
      end
      default: nxt = ARB_IDLE;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= next_owner(state, i_req, d_req, waitrequest);
  end

  assign grant = state;

  // Bus side is a straight mux of the owner's signals; the asynchronous
  // reset forces IDLE, so everything collapses to idle values while reset
  // is low without waiting for a clock.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state)
      ARB_OWN_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = 4'b1111;
        i_waitrequest = waitrequest;
      end
      ARB_OWN_D: begin
        address       = d_address;
        read          = d_read;
        write         = d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

  // Read data is not registered; each requester captures on its own
  // waitrequest-low cycle.
  assign i_readdata = readdata;
  assign d_readdata = readdata;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset)
                               !(d_read && d_write));
  a_i_hold:   assert property (@(posedge clk) disable iff (!reset)
                               (state == ARB_OWN_I) |-> i_read);
  a_d_hold:   assert property (@(posedge clk) disable iff (!reset)
                               (state == ARB_OWN_D) |-> d_req);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  grant;

  int nvec = 0;
  int nerr = 0;

  logic [1:0] exp_seq [8] = '{2'b10, 2'b01, 2'b10, 2'b01,
                              2'b10, 2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_FIRST(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    i_address    = 32'hBFC0_0000;
    i_read       = 1'b1;
    d_address    = '0;
    d_read       = 1'b0;
    d_write      = 1'b0;
    d_writedata  = '0;
    d_byteenable = '0;
    waitrequest  = 1'b0;
    readdata     = 32'h2402_0005;

    // Reset held with a fetch pending
    #1;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_iwait", i_waitrequest, 1);
    chk("rst_dwait", d_waitrequest, 1);
    tick();
    tick();
    chk("rst_hold_grant", grant, 2'b00);
    reset = 1'b1;

    // Release: fetch owns the bus one edge later, single fetch
    tick();
    chk("fetch_grant", grant, 2'b01);
    chk("fetch_addr", address, 32'hBFC0_0000);
    chk("fetch_read", read, 1);
    chk("fetch_write", write, 0);
    chk("fetch_be", byteenable, 4'b1111);
    chk("fetch_rdata", i_readdata, 32'h2402_0005);
    chk("fetch_iwait", i_waitrequest, 0);
    chk("fetch_dwait", d_waitrequest, 1);
    tick();
    i_read = 1'b0;
    chk("fetch_done_grant", grant, 2'b00);
    chk("fetch_done_read", read, 0);
    chk("fetch_done_addr", address, 0);

    // Contention: data first, then fetch back-to-back
    i_read       = 1'b1;
    i_address    = 32'hBFC0_0004;
    d_write      = 1'b1;
    d_address    = 32'h0000_1000;
    d_writedata  = 32'hDEAD_BEEF;
    d_byteenable = 4'b0011;
    tick();
    chk("cont_d_grant", grant, 2'b10);
    chk("cont_d_addr", address, 32'h0000_1000);
    chk("cont_d_write", write, 1);
    chk("cont_d_read", read, 0);
    chk("cont_d_wdata", writedata, 32'hDEAD_BEEF);
    chk("cont_d_be", byteenable, 4'b0011);
    chk("cont_d_iwait", i_waitrequest, 1);
    chk("cont_d_dwait", d_waitrequest, 0);
    tick();
    d_write = 1'b0;
    chk("cont_i_grant", grant, 2'b01);
    chk("cont_i_addr", address, 32'hBFC0_0004);
    chk("cont_i_read", read, 1);
    chk("cont_i_write", write, 0);
    chk("cont_i_be", byteenable, 4'b1111);
    chk("cont_i_wdata", writedata, 0);
    chk("cont_i_iwait", i_waitrequest, 0);
    chk("cont_i_dwait", d_waitrequest, 1);
    tick();
    i_read = 1'b0;
    chk("cont_idle_grant", grant, 2'b00);

    // Stall: data read held three cycles, completes on the fourth
    d_read       = 1'b1;
    d_address    = 32'h0000_2000;
    d_byteenable = 4'b1111;
    waitrequest  = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("stall%0d_grant", c), grant, 2'b10);
      chk($sformatf("stall%0d_addr", c), address, 32'h0000_2000);
      chk($sformatf("stall%0d_read", c), read, 1);
      chk($sformatf("stall%0d_dwait", c), d_waitrequest, 1);
      chk($sformatf("stall%0d_iwait", c), i_waitrequest, 1);
    end
    waitrequest = 1'b0;
    readdata    = 32'h1122_3344;
    #1;
    chk("stall4_dwait", d_waitrequest, 0);
    chk("stall4_rdata", d_readdata, 32'h1122_3344);
    chk("stall4_grant", grant, 2'b10);
    tick();
    d_read = 1'b0;
    chk("stall_done_grant", grant, 2'b00);

    // Fairness: both requests continuously pending
    i_read    = 1'b1;
    i_address = 32'hBFC0_0008;
    d_read    = 1'b1;
    d_address = 32'h0000_3000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("fair%0d_grant", k), grant, exp_seq[k]);
    end
    d_read = 1'b0;
    tick();
    i_read = 1'b0;
    chk("fair_end_grant", grant, 2'b00);

    // Asynchronous reset during a data stall
    d_read      = 1'b1;
    d_address   = 32'h0000_4000;
    waitrequest = 1'b1;
    tick();
    chk("areset_pre_grant", grant, 2'b10);
    chk("areset_pre_read", read, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_read", read, 0);
    chk("areset_write", write, 0);
    chk("areset_grant", grant, 2'b00);
    chk("areset_dwait", d_waitrequest, 1);
    chk("areset_addr", address, 0);
    d_read = 1'b0;
    tick();
    reset = 1'b1;
    waitrequest = 1'b0;
    tick();
    chk("post_reset_grant", grant, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
